// File: rtl/alu_pkg.sv
// Shared encodings and widths for the ALU request arbiter slice.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int RES_W  = 16;
    localparam int OP_W   = 3;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_ADD  = 3'b011,
        OP_SUB  = 3'b100,
        OP_MUL  = 3'b101,
        OP_DIV  = 3'b110,
        OP_RSVD = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    function automatic logic is_reserved(input logic [OP_W-1:0] op);
        return (op == OP_RSVD);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping at N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Cyclic scan from ptr; the first hit locks out all later candidates.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum_s       = '0;
        cand_s      = '0;
        hit_s       = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum_s       = {1'b0, ptr} + (IDX_W+1)'(k);
            cand_s      = (sum_s >= N_W) ? IDX_W'(sum_s - N_W) : sum_s[IDX_W-1:0];
            hit_s       = req[cand_s] & ~grant_valid;
            grant       = grant | ({{(N-1){1'b0}}, hit_s} << cand_s);
            grant_idx   = hit_s ? cand_s : grant_idx;
            grant_valid = grant_valid | hit_s;
        end
    end

endmodule

// File: rtl/alu_request_arbiter.sv
// Shares one ALU between N requesters with round-robin grant and one outstanding op.
// Optional WAIT timeout/abort is compiled in with `define ALU_TIMEOUT_EN.
module alu_request_arbiter
    import alu_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req_valid,
    input  logic [OP_W*N-1:0]     req_op,
    input  logic [DATA_W*N-1:0]   req_a,
    input  logic [DATA_W*N-1:0]   req_b,
    output logic [N-1:0]          req_ready,
    output logic [N-1:0]          rsp_valid,
    output logic [RES_W-1:0]      rsp_result,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  alu_begin,
    output logic [OP_W-1:0]       alu_op,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    input  logic                  alu_end,
    input  logic [RES_W-1:0]      alu_result,
    output logic                  alu_abort
);

    localparam int IDX_W = $clog2(N);

    arb_state_e        state_r, next_state_s;
    logic [IDX_W-1:0]  rr_ptr_r, owner_r, owner_next_s;
    logic [N-1:0]      grant_s;
    logic [IDX_W-1:0]  grant_idx_s;
    logic              grant_valid_s;
    logic [OP_W-1:0]   sel_op_s;
    logic [DATA_W-1:0] sel_a_s, sel_b_s;
    logic              load_s, err_s, abort_s;
    logic [RES_W-1:0]  result_s;

    logic [OP_W-1:0]   alu_op_r;
    logic [DATA_W-1:0] alu_a_r, alu_b_r;
    logic [RES_W-1:0]  rsp_result_r;
    logic [N-1:0]      rsp_valid_r;
    logic              rsp_err_r, busy_r, alu_begin_r;

    rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_rr (
        .req         (req_valid),
        .ptr         (rr_ptr_r),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // AND-OR mux of the winner's op and operands.
    always_comb begin
        sel_op_s = '0;
        sel_a_s  = '0;
        sel_b_s  = '0;
        for (int i = 0; i < N; i++) begin
            sel_op_s = sel_op_s | (req_op[OP_W*i +: OP_W] & {OP_W{grant_s[i]}});
            sel_a_s  = sel_a_s  | (req_a[DATA_W*i +: DATA_W] & {DATA_W{grant_s[i]}});
            sel_b_s  = sel_b_s  | (req_b[DATA_W*i +: DATA_W] & {DATA_W{grant_s[i]}});
        end
    end

`ifdef ALU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] wait_cnt_r;

    // Counts WAIT cycles from 0; cleared in every other state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= '0;
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= '0;
        end
    end
`else
    logic [31:0] timeout_unused_s;
    assign timeout_unused_s = 32'(TIMEOUT);
`endif

    // Next-state and per-transition response data.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        err_s        = 1'b0;
        abort_s      = 1'b0;
        result_s     = 16'h0000;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    load_s       = 1'b1;
                    err_s        = is_reserved(sel_op_s);
                    next_state_s = is_reserved(sel_op_s) ? ST_RESP : ST_LAUNCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: next_state_s = ST_WAIT;
            ST_WAIT: begin
                // alu_end has priority over an expiring timeout in the same cycle
                if (alu_end) begin
                    next_state_s = ST_RESP;
                    result_s     = alu_result;
                end
`ifdef ALU_TIMEOUT_EN
                else if (wait_cnt_r == CNT_MAX) begin
                    next_state_s = ST_RESP;
                    err_s        = 1'b1;
                    abort_s      = 1'b1;
                end
`endif
                else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
        owner_next_s = load_s ? grant_idx_s : owner_r;
    end

    // State, latched transaction and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            owner_r      <= '0;
            alu_op_r     <= 3'b000;
            alu_a_r      <= 8'h00;
            alu_b_r      <= 8'h00;
            rsp_result_r <= 16'h0000;
            rsp_valid_r  <= '0;
            rsp_err_r    <= 1'b0;
            busy_r       <= 1'b0;
            alu_begin_r  <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            busy_r      <= (next_state_s != ST_IDLE);
            alu_begin_r <= (next_state_s == ST_LAUNCH);
            rsp_valid_r <= (next_state_s == ST_RESP) ?
                           ({{(N-1){1'b0}}, 1'b1} << owner_next_s) : '0;
            rsp_err_r   <= (next_state_s == ST_RESP) ? err_s : 1'b0;
            if (next_state_s == ST_RESP) begin
                rsp_result_r <= result_s;
            end else begin
                rsp_result_r <= rsp_result_r;
            end
            if (load_s) begin
                owner_r  <= grant_idx_s;
                alu_op_r <= sel_op_s;
                alu_a_r  <= sel_a_s;
                alu_b_r  <= sel_b_s;
            end else begin
                owner_r  <= owner_r;
                alu_op_r <= alu_op_r;
                alu_a_r  <= alu_a_r;
                alu_b_r  <= alu_b_r;
            end
            if (state_r == ST_RESP) begin
                rr_ptr_r <= (owner_r == IDX_W'(N - 1)) ? '0 : owner_r + IDX_W'(1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Accept pulse and abort are same-cycle decisions; both are held low in reset.
    always_comb begin
        if (!reset && (state_r == ST_IDLE)) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
        alu_abort = abort_s & ~reset;
    end

    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_err    = rsp_err_r;
    assign busy       = busy_r;
    assign alu_begin  = alu_begin_r;
    assign alu_op     = alu_op_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;

endmodule
